// File: rtl/tick_timer_ctrl.sv
// Prescaled countdown timer: one-shot or periodic, with pause and abort.
// The prescaler divides the clock by DIV, and counter_out counts down in prescaler steps.
module tick_timer_ctrl #(
  parameter int unsigned DIV   = 50000000,
  parameter int unsigned PRE_W = 25
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [3:0]       load_val,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic [3:0]       counter_out,
  output logic [PRE_W-1:0] contador
);

  localparam int unsigned      CNT_W   = 4;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [CNT_W-1:0]   reload_q, reload_d;
  logic               mode_q, mode_d;
  logic               busy_q, busy_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;
  logic               step_en;

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pre_q    <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pre_q    <= pre_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; priority is stop > start > pause.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pre_d    = pre_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;
    step_en  = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      pre_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          pre_d = '0;
          if (start) begin
            mode_d   = mode;
            reload_d = load_val;
            if (load_val != '0) begin
              state_d = ST_RUN;
              cnt_d   = load_val;
            end else begin
              cnt_d  = '0;
              done_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else begin
            step_en = 1'b1;
          end
        end
        ST_PAUSE: begin
          // The resume edge counts as a run step, so a pause costs exactly its length.
          if (!pause) begin
            state_d = ST_RUN;
            step_en = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          pre_d   = '0;
        end
      endcase

      if (step_en) begin
        if (cnt_q == '0) begin
          // Periodic reload cycle: the prescaler holds for one edge.
          cnt_d = reload_q;
        end else if (pre_q == PRE_MAX) begin
          pre_d  = '0;
          tick_d = 1'b1;
          cnt_d  = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            done_d = 1'b1;
            if (!mode_q) begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign busy        = busy_q;
  assign tick        = tick_q;
  assign done        = done_q;
  assign counter_out = cnt_q;
  assign contador    = pre_q;

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Scoreboard bench for tick_timer_ctrl at DIV=4: expected tick/done cycles are queued
// at stimulus time and matched by a negedge monitor; state is spot-checked inline.
module tb_tick_timer_ctrl;

  localparam int unsigned PRE_W = 25;

  logic             clk      = 1'b0;
  logic             rst      = 1'b1;
  logic             start    = 1'b0;
  logic             stop     = 1'b0;
  logic             pause    = 1'b0;
  logic             mode     = 1'b0;
  logic [3:0]       load_val = 4'd0;
  logic             busy;
  logic             tick;
  logic             done;
  logic [3:0]       counter_out;
  logic [PRE_W-1:0] contador;

  int cyc     = 0;
  int n_total = 0;
  int n_bad   = 0;
  int exp_tick[$];
  int exp_done[$];

  tick_timer_ctrl #(
    .DIV   (4),
    .PRE_W (PRE_W)
  ) dut (
    .clock       (clk),
    .reset       (rst),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .mode        (mode),
    .load_val    (load_val),
    .busy        (busy),
    .tick        (tick),
    .done        (done),
    .counter_out (counter_out),
    .contador    (contador)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  // Pulse monitor: pops the scoreboard when an expected cycle arrives.
  always @(negedge clk) begin
    if (exp_tick.size() != 0 && exp_tick[0] == cyc) begin
      check_eq("tick", 32'(tick), 32'd1);
      void'(exp_tick.pop_front());
    end else if (tick) begin
      check_eq("tick_unexp", 32'(tick), 32'd0);
    end
    if (exp_done.size() != 0 && exp_done[0] == cyc) begin
      check_eq("done", 32'(done), 32'd1);
      void'(exp_done.pop_front());
    end else if (done) begin
      check_eq("done_unexp", 32'(done), 32'd0);
    end
  end

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic start_run(input logic [3:0] lv, input logic m);
    start    = 1'b1;
    load_val = lv;
    mode     = m;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic drain(input string tag);
    check_eq({tag, "_tick_left"}, 32'(exp_tick.size()), 32'd0);
    check_eq({tag, "_done_left"}, 32'(exp_done.size()), 32'd0);
    exp_tick.delete();
    exp_done.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_tick"}, 32'(tick), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_cnt"},  32'(counter_out), 32'd0);
    check_eq({tag, "_pre"},  32'(contador), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got cyc %0d want finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int t1;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // One-shot, load 3.
    t0 = cyc + 1;
    for (int k = 1; k <= 3; k++) exp_tick.push_back(t0 + 4 * k);
    exp_done.push_back(t0 + 12);
    start_run(4'd3, 1'b0);
    check_eq("os_cnt0", 32'(counter_out), 32'd3);
    check_eq("os_busy0", 32'(busy), 32'd1);
    check_eq("os_pre0", 32'(contador), 32'd0);
    wait_to(t0 + 4);
    check_eq("os_cnt4", 32'(counter_out), 32'd2);
    wait_to(t0 + 11);
    check_eq("os_busy11", 32'(busy), 32'd1);
    check_eq("os_pre11", 32'(contador), 32'd3);
    wait_to(t0 + 12);
    check_eq("os_cnt12", 32'(counter_out), 32'd0);
    check_eq("os_busy12", 32'(busy), 32'd0);
    check_eq("os_pre12", 32'(contador), 32'd0);
    wait_to(t0 + 16);
    drain("os");

    // Periodic, load 2, then stop.
    t0 = cyc + 1;
    exp_tick.push_back(t0 + 4);  exp_tick.push_back(t0 + 8);
    exp_tick.push_back(t0 + 13); exp_tick.push_back(t0 + 17);
    exp_tick.push_back(t0 + 22); exp_tick.push_back(t0 + 26);
    exp_done.push_back(t0 + 8);  exp_done.push_back(t0 + 17);
    exp_done.push_back(t0 + 26);
    start_run(4'd2, 1'b1);
    wait_to(t0 + 8);
    check_eq("per_cnt8", 32'(counter_out), 32'd0);
    check_eq("per_busy8", 32'(busy), 32'd1);
    wait_to(t0 + 9);
    check_eq("per_cnt9", 32'(counter_out), 32'd2);
    check_eq("per_pre9", 32'(contador), 32'd0);
    wait_to(t0 + 10);
    check_eq("per_pre10", 32'(contador), 32'd1);
    wait_to(t0 + 26);
    check_eq("per_busy26", 32'(busy), 32'd1);
    wait_to(t0 + 27);
    check_eq("per_cnt27", 32'(counter_out), 32'd2);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_eq("per_stop_cnt", 32'(counter_out), 32'd0);
    check_eq("per_stop_pre", 32'(contador), 32'd0);
    check_eq("per_stop_busy", 32'(busy), 32'd0);
    wait_to(t0 + 40);
    drain("per");

    // Pause for five edges in a one-shot load 2 run.
    t0 = cyc + 1;
    exp_tick.push_back(t0 + 9);
    exp_tick.push_back(t0 + 13);
    exp_done.push_back(t0 + 13);
    start_run(4'd2, 1'b0);
    wait_to(t0 + 3);
    check_eq("pz_pre3", 32'(contador), 32'd3);
    pause = 1'b1;
    for (int i = 4; i <= 8; i++) begin
      wait_to(t0 + i);
      check_eq("pz_pre_hold", 32'(contador), 32'd3);
      check_eq("pz_cnt_hold", 32'(counter_out), 32'd2);
      check_eq("pz_busy", 32'(busy), 32'd1);
    end
    pause = 1'b0;
    wait_to(t0 + 9);
    check_eq("pz_pre9", 32'(contador), 32'd0);
    check_eq("pz_cnt9", 32'(counter_out), 32'd1);
    wait_to(t0 + 13);
    check_eq("pz_busy13", 32'(busy), 32'd0);
    wait_to(t0 + 16);
    drain("pz");

    // Stop mid-run, then restart with load 1.
    t0 = cyc + 1;
    exp_tick.push_back(t0 + 4);
    exp_tick.push_back(t0 + 8);
    start_run(4'd3, 1'b0);
    wait_to(t0 + 10);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_eq("sp_cnt", 32'(counter_out), 32'd0);
    check_eq("sp_pre", 32'(contador), 32'd0);
    check_eq("sp_busy", 32'(busy), 32'd0);
    wait_to(t0 + 12);
    t1 = cyc + 1;
    exp_tick.push_back(t1 + 4);
    exp_done.push_back(t1 + 4);
    start_run(4'd1, 1'b0);
    wait_to(t1 + 4);
    check_eq("sp_re_cnt", 32'(counter_out), 32'd0);
    check_eq("sp_re_busy", 32'(busy), 32'd0);
    check_eq("sp_re_at17", 32'(t1 + 4 - t0), 32'd17);
    wait_to(t1 + 8);
    drain("sp");

    // Stop on the same edge as the final wrap suppresses tick and done.
    t0 = cyc + 1;
    start_run(4'd1, 1'b0);
    wait_to(t0 + 3);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_all_zero("spw");
    wait_to(t0 + 8);
    drain("spw");

    // Zero load: done next cycle, no tick, stays idle.
    t0 = cyc + 1;
    exp_done.push_back(t0);
    start_run(4'd0, 1'b0);
    check_eq("z_busy", 32'(busy), 32'd0);
    check_eq("z_cnt", 32'(counter_out), 32'd0);
    wait_to(t0 + 6);
    drain("z");

    // Start while busy is ignored, including its mode.
    t0 = cyc + 1;
    for (int k = 1; k <= 3; k++) exp_tick.push_back(t0 + 4 * k);
    exp_done.push_back(t0 + 12);
    start_run(4'd3, 1'b0);
    wait_to(t0 + 5);
    start_run(4'd5, 1'b1);
    check_eq("ig_cnt", 32'(counter_out), 32'd2);
    wait_to(t0 + 12);
    check_eq("ig_busy12", 32'(busy), 32'd0);
    check_eq("ig_cnt12", 32'(counter_out), 32'd0);
    wait_to(t0 + 16);
    drain("ig");

    // Start with pause high in IDLE enters RUN; pause applies from the next edge.
    t0 = cyc + 1;
    exp_tick.push_back(t0 + 6);
    exp_done.push_back(t0 + 6);
    pause = 1'b1;
    start_run(4'd1, 1'b0);
    check_eq("sp_pz_busy", 32'(busy), 32'd1);
    check_eq("sp_pz_pre0", 32'(contador), 32'd0);
    wait_to(t0 + 2);
    check_eq("sp_pz_pre2", 32'(contador), 32'd0);
    pause = 1'b0;
    wait_to(t0 + 5);
    check_eq("sp_pz_pre5", 32'(contador), 32'd3);
    wait_to(t0 + 6);
    check_eq("sp_pz_busy6", 32'(busy), 32'd0);
    wait_to(t0 + 10);
    drain("sppz");

    // Reset mid-run, then a fresh one-shot start.
    t0 = cyc + 1;
    exp_tick.push_back(t0 + 4);
    start_run(4'd3, 1'b0);
    wait_to(t0 + 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("rmid");
    wait_to(t0 + 8);
    t1 = cyc + 1;
    exp_tick.push_back(t1 + 4);
    exp_done.push_back(t1 + 4);
    start_run(4'd1, 1'b0);
    check_eq("rmid_re_cnt", 32'(counter_out), 32'd1);
    wait_to(t1 + 4);
    check_eq("rmid_re_busy", 32'(busy), 32'd0);
    wait_to(t1 + 12);
    drain("rmid");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/tick_timer_ctrl.md
TICK_TIMER_CTRL -- requirements
Module: tick_timer_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 50000000, meaning clock cycles per count step (prescaler period, legal range 2..2^25).
REQ-002 SHALL have parameter PRE_W, default 25, meaning prescaler width in bits.
REQ-003 SHALL have port clock  in  1  meaning the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset  in  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  meaning a request to load and run; it is sampled on each edge.
REQ-006 SHALL have port stop  in  1  meaning abort to IDLE.
REQ-007 SHALL have port pause  in  1  meaning a level input that holds the timer while high.
REQ-008 SHALL have port mode  in  1  meaning 0 = one-shot and 1 = periodic; it is latched on start.
REQ-009 SHALL have port load_val  in  4  meaning the count-step reload value; it is latched on start.
REQ-010 SHALL have port busy  out  1  meaning high while the state is RUN or PAUSE.
REQ-011 SHALL have port tick  out  1  meaning a registered 1-cycle pulse on each prescaler wrap.
REQ-012 SHALL have port done  out  1  meaning a registered 1-cycle pulse when the count reaches 0.
REQ-013 SHALL have port counter_out  out  4  meaning the remaining count steps.
REQ-014 SHALL have port contador  out  PRE_W  meaning the current prescaler value.

Function
REQ-015 SHALL implement the states IDLE, RUN and PAUSE, with all outputs registered.
REQ-016 SHALL apply input priority per edge as: reset > stop > start > pause.
REQ-017 SHALL, on start in IDLE with load_val != 0, set: state to RUN; counter_out to load_val; contador to 0; latched mode to mode; latched reload to load_val.
REQ-018 SHALL, on start in IDLE with load_val == 0, stay in IDLE and pulse done on the next cycle, with no tick.
REQ-019 SHALL ignore start while in RUN or PAUSE, with no reload and no error.
REQ-020 SHALL, in RUN, set contador to contador+1 on each edge; when contador == DIV-1, it SHALL instead set contador to 0, pulse tick and decrement counter_out.
REQ-021 SHALL, on a tick when counter_out == 1, set counter_out to 0 and pulse done in the same cycle as tick.
REQ-022 SHALL, on reaching 0 in one-shot mode, go to IDLE and hold counter_out at 0.
REQ-023 SHALL, on reaching 0 in periodic mode, set counter_out to the latched reload in the cycle after done and stay in RUN; the wrap edge SHALL load 0, and the next edge SHALL load the reload.
REQ-024 SHALL NOT advance the prescaler on the reload cycle in periodic mode, so the period is exactly DIV*reload+1 cycles from one done to the next.
REQ-025 SHALL transition RUN to PAUSE when pause is high and PAUSE to RUN when pause is low; in PAUSE, contador and counter_out SHALL hold and no tick or done SHALL occur.
REQ-026 SHALL resume counting from the held contador value after PAUSE, with no lost or extra cycles.
REQ-027 SHALL, on stop in any state, go to IDLE with counter_out = 0 and contador = 0, and SHALL suppress any done or tick that would coincide with it.
REQ-028 SHALL give start precedence over pause on the same edge in IDLE, entering RUN; pause SHALL then take effect on the next edge.
REQ-029 SHALL, in IDLE, hold contador at 0 and emit no ticks.
REQ-030 SHALL assert done at the end of the DIV*load_val-th cycle after the edge that accepted start, in one-shot mode with no pause.
REQ-031 SHALL ensure contador never exceeds DIV-1 and counter_out never underflows below 0.

Reset
REQ-032 SHALL, while reset is high, go to state IDLE with counter_out = 0, contador = 0, busy = 0, tick = 0, done = 0, latched mode = 0 and latched reload = 0.
REQ-033 SHALL, on reset asserted mid-RUN, abort on that edge with no done pulse; the first start after reset release SHALL behave as from power-up.

Verification (DIV=4)
REQ-034 SHALL verify one-shot: start with load_val=3, mode=0 -> ticks 4, 8 and 12 cycles after start; done at 12 with counter_out=0; busy falls at 12.
REQ-035 SHALL verify periodic: start with load_val=2, mode=1 -> done at 8, then counter_out=2 at 9, and done at 17 and 26; busy stays 1.
REQ-036 SHALL verify pause: one-shot load_val=2, with pause high from cycle 3 to 7 -> contador frozen at 3 and no tick during the pause; done at 8+5=13.
REQ-037 SHALL verify stop and restart: stop at cycle 11 of a load_val=3 run -> no done; counter_out=0 and contador=0 at 12; a start at 13 with load_val=1 -> done at 17.
REQ-038 SHALL verify zero load and ignored start: start with load_val=0 -> done 1 cycle later with no tick; start with load_val=5 while busy -> counter_out is unaffected.
REQ-039 SHALL verify reset mid-run: reset at cycle 6 of a load_val=3 run -> all outputs are 0 on the next cycle and no done occurs.
